// File: rtl/vga_timing_pattern_if.sv
// vga_timing_pattern_if: VGA pixel bus of 4-bit R/G/B as discrete bits plus HSYNC/VSYNC.
interface vga_timing_pattern_if;
    logic r0, r1, r2, r3;
    logic g0, g1, g2, g3;
    logic b0, b1, b2, b3;
    logic hs, vs;
    modport master (output r0, r1, r2, r3, g0, g1, g2, g3, b0, b1, b2, b3, hs, vs);
    modport slave (input r0, r1, r2, r3, g0, g1, g2, g3, b0, b1, b2, b3, hs, vs);
endinterface

// File: rtl/vga_timing_pattern.sv
// vga_timing_pattern: 640x480@60 VGA timing with 8 colour bars and a 1-pixel white frame.
// Define VGA_CHECKER_EN to replace the bars with a 32x32 black/white checkerboard.
module vga_timing_pattern #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP = 33,
    parameter bit SYNC_ACTIVE = 1'b0
) (
    input logic clk,
    input logic rst,
    vga_timing_pattern_if.master vga
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int VS_START = V_ACTIVE + V_FP;
    logic [9:0] count_h_q, count_h_d, count_v_q, count_v_d;
    logic [11:0] rgb_q, rgb_d, pat;
    logic hs_q, hs_d, vs_q, vs_d;
    logic h_last, blank, wht;
`ifndef VGA_CHECKER_EN
    localparam int BAR_W = H_ACTIVE / 8;
    logic [2:0] bar;
`endif
    always_comb begin
        h_last = count_h_q == 10'(H_TOTAL - 1);
        count_h_d = h_last ? '0 : count_h_q + 10'd1;
        count_v_d = !h_last ? count_v_q : (count_v_q == 10'(V_TOTAL - 1)) ? '0 : count_v_q + 10'd1;
        blank = (count_h_q >= 10'(H_ACTIVE)) | (count_v_q >= 10'(V_ACTIVE));
        wht = !blank & ((count_h_q == '0) | (count_h_q == 10'(H_ACTIVE - 1)) |
                        (count_v_q == '0) | (count_v_q == 10'(V_ACTIVE - 1)));
`ifdef VGA_CHECKER_EN
        pat = {12{count_h_q[5] ^ count_v_q[5]}};
`else
        bar = '0;
        for (int i = 1; i < 8; i++) bar = bar + {2'b0, count_h_q >= 10'(i * BAR_W)};
        // bar order white,yellow,cyan,green,magenta,red,blue,black maps onto inverted index bits
        pat = {{4{!bar[1]}}, {4{!bar[2]}}, {4{!bar[0]}}};
`endif
        rgb_d = blank ? '0 : wht ? '1 : pat;
        hs_d = (count_h_q >= 10'(HS_START) && count_h_q <= 10'(HS_START + H_SYNC - 1)) ? SYNC_ACTIVE : !SYNC_ACTIVE;
        vs_d = (count_v_q >= 10'(VS_START) && count_v_q <= 10'(VS_START + V_SYNC - 1)) ? SYNC_ACTIVE : !SYNC_ACTIVE;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_h_q <= '0;
            count_v_q <= '0;
            rgb_q <= '0;
            hs_q <= !SYNC_ACTIVE;
            vs_q <= !SYNC_ACTIVE;
        end else begin
            count_h_q <= count_h_d;
            count_v_q <= count_v_d;
            rgb_q <= rgb_d;
            hs_q <= hs_d;
            vs_q <= vs_d;
        end
    end
    assign {vga.r3, vga.r2, vga.r1, vga.r0, vga.g3, vga.g2, vga.g1, vga.g0,
            vga.b3, vga.b2, vga.b1, vga.b0} = rgb_q;
    assign vga.hs = hs_q;
    assign vga.vs = vs_q;
endmodule

// File: tb/tb_vga_timing_pattern.sv
// tb_vga_timing_pattern: checks a full-size instance and a short-frame instance cycle by cycle
// against a position-based reference model, with randomly timed asynchronous resets.
module tb_vga_timing_pattern;
    logic clk, rst;
    int p, checks, failures;
    vga_timing_pattern_if vga_a ();
    vga_timing_pattern_if vga_b ();
    vga_timing_pattern dut_a (.clk(clk), .rst(rst), .vga(vga_a));
    // same horizontal timing, 15-line frame so vertical sync and wrap are reached quickly
    vga_timing_pattern #(.V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3)) dut_b (.clk(clk), .rst(rst), .vga(vga_b));
    initial clk = 1'b0;
    always #5 clk = ~clk;
    wire [13:0] obs_a = {vga_a.r3, vga_a.r2, vga_a.r1, vga_a.r0, vga_a.g3, vga_a.g2, vga_a.g1, vga_a.g0,
                         vga_a.b3, vga_a.b2, vga_a.b1, vga_a.b0, vga_a.hs, vga_a.vs};
    wire [13:0] obs_b = {vga_b.r3, vga_b.r2, vga_b.r1, vga_b.r0, vga_b.g3, vga_b.g2, vga_b.g1, vga_b.g0,
                         vga_b.b3, vga_b.b2, vga_b.b1, vga_b.b0, vga_b.hs, vga_b.vs};
    function automatic logic [13:0] model(int pos, int va, int vt, int vss, int vse);
        logic [11:0] bars [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};
        int h = pos % 800;
        int v = (pos / 800) % vt;
        logic [11:0] rgb;
        if (h >= 640 || v >= va) rgb = 12'h000;
        else if (h == 0 || h == 639 || v == 0 || v == va - 1) rgb = 12'hFFF;
`ifdef VGA_CHECKER_EN
        else rgb = (((h / 32) + (v / 32)) % 2 == 1) ? 12'hFFF : 12'h000;
`else
        else rgb = bars[h / 80];
`endif
        return {rgb, !(h >= 656 && h <= 751), !(v >= vss && v <= vse)};
    endfunction
    task automatic chk(string tag, logic [13:0] got, logic [13:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        p++;
        #1;
        chk($sformatf("full p=%0d", p - 1), obs_a, model(p - 1, 480, 525, 490, 491));
        chk($sformatf("short p=%0d", p - 1), obs_b, model(p - 1, 8, 15, 10, 11));
    endtask
    task automatic hold_reset(int n);
        #($urandom_range(1, 3));
        rst = 1'b0;
        #1;
        chk("rst_async_a", obs_a, 14'h0003);
        chk("rst_async_b", obs_b, 14'h0003);
        repeat (n) begin
            @(posedge clk);
            #1;
            chk("rst_hold_a", obs_a, 14'h0003);
            chk("rst_hold_b", obs_b, 14'h0003);
        end
        @(negedge clk);
        rst = 1'b1;
        p = 0;
    endtask
    initial begin
        checks = 0;
        failures = 0;
        p = 0;
        rst = 1'b1;
        #2;
        hold_reset(5);
        repeat (2400) step();
        while (p % 800 != 300) step();
        hold_reset($urandom_range(1, 5));
        repeat (2 * 12000 + 800) step();
        repeat (3) begin
            repeat ($urandom_range(100, 3000)) step();
            hold_reset($urandom_range(1, 8));
        end
        repeat (1700) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
